// File: rtl/reg_share_arbiter_if.sv
// Bundle for the shared-register write arbiter.
// Requesters drive req0/req1/d0/d1. The arbiter drives the acks, the register
// contents and the status signals.
//   master : requester side (drives requests and data, observes results)
//   slave  : arbiter side   (observes requests and data, drives results)
interface reg_share_arbiter_if #(
  parameter int WIDTH = 8
);
  logic             req0;
  logic             req1;
  logic [WIDTH-1:0] d0;
  logic [WIDTH-1:0] d1;
  logic             ack0;
  logic             ack1;
  logic [WIDTH-1:0] q;
  logic             q_valid;
  logic             owner;
  logic             busy;
  logic [7:0]       wr_count;

  modport master (
    output req0, req1, d0, d1,
    input  ack0, ack1, q, q_valid, owner, busy, wr_count
  );

  modport slave (
    input  req0, req1, d0, d1,
    output ack0, ack1, q, q_valid, owner, busy, wr_count
  );
endinterface

// File: rtl/reg_share_arbiter.sv
// Round-robin arbiter and write sequencer for one shared WIDTH-bit register.
// A request sampled in IDLE moves the FSM to XFER for exactly one cycle.
// The edge leaving XFER does the following:
//   - commits d_sel into q
//   - pulses ack_sel for one cycle
//   - locks the register for HOLD cycles
// Ports:
//   clk   : clock, rising edge active
//   rst_n : asynchronous active-low reset
//   bus   : slave side of reg_share_arbiter_if
//           - inputs:  req0/req1, d0/d1
//           - outputs: ack0/ack1, q, q_valid, owner, busy, wr_count
// HOLD must lie in 0..15.
module reg_share_arbiter #(
  parameter int WIDTH = 8,
  parameter int HOLD  = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  reg_share_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_XFER = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  localparam logic [3:0] HOLD_CNT = 4'(HOLD);

  state_t           state_q;
  logic             sel_q;
  logic             last_q;
  logic [3:0]       hold_q;
  logic [WIDTH-1:0] data_q;
  logic             valid_q;
  logic             owner_q;
  logic             ack0_q;
  logic             ack1_q;
  logic [7:0]       cnt_q;

  logic             eff0_d;
  logic             eff1_d;
  logic             sel_d;

  // A requester is masked while its own ack is high.
  // Without the mask, a level request held across the ack would be
  // regranted immediately when HOLD=0.
  assign eff0_d = bus.req0 & ~ack0_q;
  assign eff1_d = bus.req1 & ~ack1_q;

  // Tie goes to whoever did not write last.
  // Otherwise the sole requester wins. The value is only used when at
  // least one effective request is present.
  assign sel_d = (eff0_d & eff1_d) ? ~last_q : eff1_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      sel_q   <= 1'b0;
      last_q  <= 1'b1;
      hold_q  <= 4'd0;
      data_q  <= '0;
      valid_q <= 1'b0;
      owner_q <= 1'b0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      cnt_q   <= 8'd0;
    end else begin
      ack0_q <= 1'b0;
      ack1_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (eff0_d | eff1_d) begin
            sel_q   <= sel_d;
            state_q <= S_XFER;
          end
        end
        S_XFER: begin
          // Committed unconditionally: a request dropped during XFER
          // still completes with the data present at this edge.
          data_q  <= sel_q ? bus.d1 : bus.d0;
          ack0_q  <= ~sel_q;
          ack1_q  <= sel_q;
          owner_q <= sel_q;
          last_q  <= sel_q;
          valid_q <= 1'b1;
          cnt_q   <= cnt_q + 8'd1;
          hold_q  <= HOLD_CNT;
          state_q <= (HOLD_CNT != 4'd0) ? S_HOLD : S_IDLE;
        end
        S_HOLD: begin
          hold_q <= hold_q - 4'd1;
          if (hold_q == 4'd1) begin
            state_q <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.q        = data_q;
  assign bus.q_valid  = valid_q;
  assign bus.owner    = owner_q;
  assign bus.ack0     = ack0_q;
  assign bus.ack1     = ack1_q;
  assign bus.busy     = (state_q != S_IDLE);
  assign bus.wr_count = cnt_q;

endmodule

// File: tb/tb_reg_share_arbiter.sv
`timescale 1ns/1ps
// Two instances run side by side on the same request stimulus:
//   - dut    : HOLD=2
//   - dut_h0 : HOLD=0
// A timeline model predicts every output after each edge.
// The model tracks the following per instance:
//   - a pending commit
//   - how many edges arbitration stays blind
//   - who is favoured on a tie
module tb_reg_share_arbiter;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic         req0_s = 1'b0;
  logic         req1_s = 1'b0;
  logic [W-1:0] d0_s = '0;
  logic [W-1:0] d1_s = '0;

  reg_share_arbiter_if #(.WIDTH(W)) bus_a ();
  reg_share_arbiter_if #(.WIDTH(W)) bus_b ();

  assign bus_a.req0 = req0_s;
  assign bus_a.req1 = req1_s;
  assign bus_a.d0   = d0_s;
  assign bus_a.d1   = d1_s;
  assign bus_b.req0 = req0_s;
  assign bus_b.req1 = req1_s;
  assign bus_b.d0   = d0_s;
  assign bus_b.d1   = d1_s;

  reg_share_arbiter #(.WIDTH(W), .HOLD(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a)
  );

  reg_share_arbiter #(.WIDTH(W), .HOLD(0)) dut_h0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b)
  );

  // ---------------- reference model ----------------
  int           hv [2] = '{2, 0};
  int           m_wait [2];
  bit           m_commit [2];
  bit           m_win [2];
  bit           m_prio [2];
  logic [W-1:0] m_q [2];
  bit           m_valid [2];
  bit           m_owner [2];
  logic [7:0]   m_cnt [2];
  bit           m_ack0 [2];
  bit           m_ack1 [2];

  int total = 0;
  int bad   = 0;

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_wait[k]   = 0;
      m_commit[k] = 1'b0;
      m_win[k]    = 1'b0;
      m_prio[k]   = 1'b0;
      m_q[k]      = '0;
      m_valid[k]  = 1'b0;
      m_owner[k]  = 1'b0;
      m_cnt[k]    = 8'd0;
      m_ack0[k]   = 1'b0;
      m_ack1[k]   = 1'b0;
    end
  endtask

  // Predict the effect of the coming rising edge, using the current inputs.
  task automatic model_edge(int k);
    bit e0;
    bit e1;
    e0 = req0_s && !m_ack0[k];
    e1 = req1_s && !m_ack1[k];
    if (m_commit[k]) begin
      m_q[k]      = m_win[k] ? d1_s : d0_s;
      m_owner[k]  = m_win[k];
      m_prio[k]   = !m_win[k];
      m_valid[k]  = 1'b1;
      m_cnt[k]    = m_cnt[k] + 8'd1;
      m_ack0[k]   = !m_win[k];
      m_ack1[k]   = m_win[k];
      m_commit[k] = 1'b0;
      m_wait[k]   = hv[k];
    end else begin
      m_ack0[k] = 1'b0;
      m_ack1[k] = 1'b0;
      if (m_wait[k] > 0) begin
        m_wait[k]--;
      end else if (e0 || e1) begin
        m_win[k]    = (e0 && e1) ? m_prio[k] : e1;
        m_commit[k] = 1'b1;
      end
    end
  endtask

  task automatic chk(string tag, int k, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s hold=%0d observed=%0h expected=%0h", tag, hv[k], obs, exp);
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      chk("q",        k, (k == 1) ? 32'(bus_b.q)        : 32'(bus_a.q),        32'(m_q[k]));
      chk("q_valid",  k, (k == 1) ? 32'(bus_b.q_valid)  : 32'(bus_a.q_valid),  32'(m_valid[k]));
      chk("owner",    k, (k == 1) ? 32'(bus_b.owner)    : 32'(bus_a.owner),    32'(m_owner[k]));
      chk("ack0",     k, (k == 1) ? 32'(bus_b.ack0)     : 32'(bus_a.ack0),     32'(m_ack0[k]));
      chk("ack1",     k, (k == 1) ? 32'(bus_b.ack1)     : 32'(bus_a.ack1),     32'(m_ack1[k]));
      chk("wr_count", k, (k == 1) ? 32'(bus_b.wr_count) : 32'(bus_a.wr_count), 32'(m_cnt[k]));
      chk("busy",     k, (k == 1) ? 32'(bus_b.busy)     : 32'(bus_a.busy),
          32'(m_commit[k] || (m_wait[k] > 0)));
    end
  endtask

  task automatic tick();
    model_edge(0);
    model_edge(1);
    @(posedge clk);
    #1;
    check_all();
    for (int k = 0; k < 2; k++) begin
      if (m_ack0[k] || m_ack1[k]) begin
        $display("write hold=%0d owner=%0d q=%02h count=%0d",
                 hv[k], m_owner[k], m_q[k], m_cnt[k]);
      end
    end
  endtask

  // Reset asserted and checked between clock edges.
  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    #1 rst_n = 1'b1;
  endtask

  initial begin : stim
    int busy_n;
    int found;
    int owners [$];
    logic [W-1:0] qs [$];
    int ack_t [$];

    @(posedge clk);
    #1;

    // Reset with no clock edge.
    do_reset();

    // Single request, HOLD=2 instance.
    req0_s = 1'b1;
    d0_s   = 8'hA5;
    busy_n = 0;
    tick();
    busy_n += int'(bus_a.busy);
    tick();
    busy_n += int'(bus_a.busy);
    chk("single_ack0",  0, 32'(bus_a.ack0),     32'd1);
    chk("single_q",     0, 32'(bus_a.q),        32'hA5);
    chk("single_owner", 0, 32'(bus_a.owner),    32'd0);
    chk("single_valid", 0, 32'(bus_a.q_valid),  32'd1);
    chk("single_cnt",   0, 32'(bus_a.wr_count), 32'd1);
    req0_s = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      busy_n += int'(bus_a.busy);
    end
    chk("single_busy_cycles", 0, 32'(busy_n), 32'd3);

    // Tie with both requests held: alternation, one ack every 4 cycles.
    do_reset();
    req0_s = 1'b1;
    req1_s = 1'b1;
    d0_s   = 8'h11;
    d1_s   = 8'h22;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (bus_a.ack0 || bus_a.ack1) begin
        owners.push_back(int'(bus_a.owner));
        qs.push_back(bus_a.q);
        ack_t.push_back(i);
      end
    end
    chk("tie_ack_count", 0, 32'(owners.size()), 32'd4);
    for (int i = 0; i < 4 && i < owners.size(); i++) begin
      chk("tie_owner", 0, 32'(owners[i]), 32'(i % 2));
      chk("tie_q",     0, 32'(qs[i]),     (i % 2 == 0) ? 32'h11 : 32'h22);
      if (i > 0) chk("tie_spacing", 0, 32'(ack_t[i] - ack_t[i-1]), 32'd4);
    end
    req0_s = 1'b0;
    req1_s = 1'b0;
    tick();

    // req1 raised during HOLD is ignored until IDLE.
    do_reset();
    req0_s = 1'b1;
    d0_s   = 8'h3C;
    tick();
    tick();
    req0_s = 1'b0;
    req1_s = 1'b1;
    d1_s   = 8'hC3;
    found  = -1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (bus_a.ack1 && found < 0) found = i;
    end
    chk("hold_ignore_ack1_delay", 0, 32'(found), 32'd4);
    chk("hold_ignore_q",          0, 32'(bus_a.q), 32'hC3);
    req1_s = 1'b0;
    tick();

    // HOLD=0: req0 held across its ack is masked; pending req1 wins next edge.
    do_reset();
    req0_s = 1'b1;
    req1_s = 1'b1;
    d0_s   = 8'h5A;
    d1_s   = 8'hA5;
    tick();
    tick();
    chk("h0_ack0",       1, 32'(bus_b.ack0), 32'd1);
    tick();
    chk("h0_no_regrant", 1, 32'(bus_b.ack0), 32'd0);
    chk("h0_busy",       1, 32'(bus_b.busy), 32'd1);
    tick();
    chk("h0_ack1",       1, 32'(bus_b.ack1),  32'd1);
    chk("h0_owner",      1, 32'(bus_b.owner), 32'd1);
    req0_s = 1'b0;
    req1_s = 1'b0;
    tick();

    // Reset during XFER: no ack, nothing committed.
    do_reset();
    req0_s = 1'b1;
    d0_s   = 8'hFF;
    tick();
    chk("xfer_busy", 0, 32'(bus_a.busy), 32'd1);
    do_reset();
    chk("xfer_rst_q",   0, 32'(bus_a.q),        32'd0);
    chk("xfer_rst_cnt", 0, 32'(bus_a.wr_count), 32'd0);
    req0_s = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("xfer_rst_no_ack", 0, 32'(bus_a.ack0), 32'd0);
    end

    // 256 writes on the HOLD=2 instance: the count wraps to zero.
    do_reset();
    req0_s = 1'b1;
    req1_s = 1'b1;
    for (int i = 0; i < 1024; i++) begin
      if (m_ack0[0]) d0_s = W'($urandom);
      if (m_ack1[0]) d1_s = W'($urandom);
      tick();
    end
    chk("wrap_cnt",   0, 32'(bus_a.wr_count), 32'd0);
    chk("wrap_valid", 0, 32'(bus_a.q_valid),  32'd1);
    req0_s = 1'b0;
    req1_s = 1'b0;
    tick();

    // Randomized traffic with occasional mid-cycle resets.
    for (int i = 0; i < 2000; i++) begin
      if (!req0_s) begin
        if ($urandom_range(2) == 0) begin
          req0_s = 1'b1;
          d0_s   = W'($urandom);
        end
      end else if (m_ack0[0] || m_ack0[1]) begin
        if ($urandom_range(1) == 0) req0_s = 1'b0;
        else d0_s = W'($urandom);
      end
      if (!req1_s) begin
        if ($urandom_range(2) == 0) begin
          req1_s = 1'b1;
          d1_s   = W'($urandom);
        end
      end else if (m_ack1[0] || m_ack1[1]) begin
        if ($urandom_range(1) == 0) req1_s = 1'b0;
        else d1_s = W'($urandom);
      end
      if ($urandom_range(199) == 0) begin
        do_reset();
      end
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reg_share_arbiter.md
# reg_share_arbiter

- Round-robin arbiter and write sequencer for one shared WIDTH-bit storage register built from asynchronously reset D flip-flops.
- Two requesters compete for write access. The block grants one requester, commits its data into the shared register and acknowledges with a one-cycle pulse.
- After the commit, the register is locked for HOLD cycles so downstream logic sees a stable value.
- Sits between the requesting logic and the consumers of `q`.

## Interface
- WIDTH, 8, data width of the shared register
- HOLD, 2, lock cycles after each write; legal range 0..15

- clk  input  1  clock, rising edge active
- rst_n  input  1  reset, asynchronous, active-low
- req0  input  1  requester 0 write request, level
- req1  input  1  requester 1 write request, level
- d0  input  WIDTH  requester 0 write data
- d1  input  WIDTH  requester 1 write data
- ack0  output  1  one-cycle pulse: requester 0 write committed
- ack1  output  1  one-cycle pulse: requester 1 write committed
- q  output  WIDTH  shared register contents
- q_valid  output  1  high once `q` has been written at least once since reset (sticky)
- owner  output  1  id of the last writer
- busy  output  1  high when state is not IDLE
- wr_count  output  8  number of committed writes, wraps modulo 256

## Operation
- Reset (rst_n=0) takes effect immediately, with no clock required, and sets:
  - state=IDLE, q=0, q_valid=0, owner=0, ack0=ack1=0, busy=0, wr_count=0
  - internal `last`=1 (so req0 wins the first tie), internal `sel`=0, hold counter=0
- Effective requests are eff_i = req_i & ~ack_i. A requester whose ack is high in the current cycle is masked for that cycle.
- IDLE:
  - If neither eff_i is set: stay in IDLE.
  - If exactly one eff_i is set: sel <= i, go to XFER.
  - If both are set: sel <= ~last, go to XFER.
- XFER (exactly one cycle), on the exiting edge:
  - q <= d_sel
  - ack_sel <= 1
  - owner <= sel, last <= sel
  - q_valid <= 1
  - wr_count <= wr_count+1
  - hold counter <= HOLD
  - Next state is HOLD if HOLD>0, otherwise IDLE.
- HOLD:
  - The counter decrements each cycle. The edge that sees counter==1 moves the state to IDLE.
  - All requests are ignored while in HOLD.
- XFER is committed once entered. If req_sel deasserts during XFER, the write still completes with d_sel sampled at the exiting edge.
- ack0 and ack1 are registered. Each is high for exactly one cycle and is never high at the same time as the other.
- Requesters must hold d_i stable from raising req_i until they see ack_i. They must drop req_i, or present new data, in the cycle after ack_i.
- q changes only on an XFER-exiting edge or on reset.

## Timing
- E1: the edge that samples a request in IDLE; the state becomes XFER.
- E2: the edge after E1.
  - q, owner and wr_count update.
  - ack is high during the cycle after E2.
  - Request-to-ack latency is 2 edges.
- HOLD occupies exactly HOLD cycles. The state returns to IDLE at edge E2+HOLD.
- The earliest next grant is sampled at E2+HOLD+1. Sustained throughput is one write per HOLD+2 cycles.
- HOLD=0: the state returns to IDLE at E2.
  - The just-served requester is masked while its ack is high.
  - The other requester can be granted at the next edge.
- busy is high from the cycle after E1 through the last HOLD cycle.
- Reset asserted mid-XFER or mid-HOLD:
  - All outputs return to reset values immediately.
  - No ack is issued and no write is committed.
- wr_count wraps from 255 to 0 with no other effect.

## Test plan
- **Reset:** apply rst_n=0 mid-cycle, with no clock edge -> q=0, q_valid=0, owner=0, busy=0, wr_count=0 immediately.
- **Single request:** req0=1, d0=8'hA5, HOLD=2 -> ack0 pulses one cycle after E2; q=8'hA5, owner=0, q_valid=1, wr_count=1; busy high for 3 cycles.
- **Tie and alternation:** req0=req1=1 held continuously, d0=8'h11, d1=8'h22 -> grants go 0,1,0,1; q sequence 11,22,11,22; one ack every 4 cycles (HOLD=2).
- **Request ignored in HOLD:** req1 raised during HOLD after a req0 write -> no grant until IDLE; ack1 arrives 2 edges after the first IDLE sampling edge.
- **HOLD=0 masking:** req0 held high across its ack -> no back-to-back regrant of requester 0 in the ack cycle; a pending req1 is granted at the next edge.
- **Reset mid-operation:** rst_n pulsed low during XFER with d0=8'hFF -> no ack0; q=0; wr_count=0. Then 256 writes -> wr_count wraps to 0.
